shift_ctrl: RTL and testbench
=============================

# shift_ctrl

Command sequencer for the 4-bit load/shift-right/shift-left register. It accepts one command at a time over a valid/ready handshake: load a value, then shift it N places in one direction. It drives the register's `ld`/`sr`/`sl`/`d_in` controls cycle by cycle and returns the final register contents with a one-cycle completion pulse. It sits between the register and any upstream master, so that master never has to time register strobes itself.

## Interface
- `WIDTH`, 4: data width; must match the controlled register.
- `CNT_W`, 3: width of the shift-count field; counts 0..2^CNT_W-1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_data`  in  WIDTH  value to load.
- `cmd_dir`  in  1  shift direction: 0 = right (`sr`), 1 = left (`sl`).
- `cmd_count`  in  CNT_W  number of single-bit shifts after the load.
- `hold`  in  1  stall shifting; the FSM stays in SHIFT.
- `abort`  in  1  cancel the command in progress.
- `ld`  out  1  register load strobe.
- `sr`  out  1  register shift-right strobe.
- `sl`  out  1  register shift-left strobe.
- `d_in`  out  WIDTH  load value to the register.
- `q_in`  in  WIDTH  current register output `q`.
- `busy`  out  1  command in progress (state ≠ IDLE).
- `done`  out  1  one-cycle completion pulse.
- `result`  out  WIDTH  register contents captured at completion.

## Operation
- **States:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid`, latch `cmd_data`, `cmd_dir` and `cmd_count` into internal registers, then go to LOAD.
- **LOAD:**
  - `ld` = 1 and `d_in` = latched data for exactly one cycle.
  - Then go to DONE if the count is 0; otherwise load `remaining` with the count and go to SHIFT.
- **SHIFT, `hold` = 0:**
  - Assert `sr` (dir = 0) or `sl` (dir = 1) for this cycle and decrement `remaining`.
  - When `remaining` = 1 at the edge, go to DONE.
- **SHIFT, `hold` = 1:** no strobe, `remaining` unchanged, stay in SHIFT.
- **DONE:**
  - No strobes; the register has now settled.
  - At the edge leaving DONE: `result` ← `q_in`, `done` ← 1 for the following cycle only, next state IDLE.
- **Strobe exclusivity:** at most one of `ld`/`sr`/`sl` is high in any cycle. Strobes are decoded from the state, gated by `hold` and `abort`.
- **`d_in`:** equals the latched data in every cycle (stable; the register samples it only under `ld`).
- **`abort` in LOAD or SHIFT:**
  - Strobes are forced low in that same cycle and the next state is IDLE.
  - No `done` pulse and no `result` update.
  - `abort` is ignored in IDLE and DONE.
- **Counts ≥ WIDTH:** legal. The register shifts to zero and the remaining strobes are still issued; there is no early termination.
- **`cmd_valid` while busy:** ignored (`cmd_ready` = 0); the upstream master must hold it.
- **Register reset:** the controller never resets the register; the register's own reset is driven separately.

## Timing
- **Reset:**
  - State = IDLE.
  - `ld`/`sr`/`sl`/`done`/`busy` = 0; `result` = 0; `d_in` = 0; internal count = 0.
  - `cmd_ready` = 0 while `rst` is high, 1 from the first cycle after `rst` falls.
- **Handshake:** a transfer occurs on an edge where `cmd_valid` & `cmd_ready`.
- **Latency for count N, no `hold`** (accept edge = edge 0):
  - `ld` in cycle 1.
  - Shift strobes in cycles 2..N+1.
  - DONE in cycle N+2.
  - `done` and the new `result` in cycle N+3.
- **Back-to-back:**
  - `cmd_ready` is high again in the `done` cycle.
  - The minimum command spacing is N+3 cycles.
- **`hold`:** each `hold` cycle in SHIFT adds exactly one cycle of latency. `hold` has no effect in other states.
- **Reset mid-operation:**
  - Returns to IDLE at the next edge and suppresses `done`.
  - The register keeps whatever partial value it holds.
- **`result`:** holds its value until the next completion.

## Test plan
- **Load + shift right:** `cmd_data` = 1011, dir = 0, count = 2 → `ld` cycle 1 with `d_in` = 1011, `sr` cycles 2–3, `done` cycle 5 with `result` = 0010.
- **Load + shift left, then count 0:**
  - `cmd_data` = 0011, dir = 1, count = 1 → `result` = 0110.
  - A following command with `cmd_data` = 1001, count = 0 → `ld` only, `done` 3 cycles after accept, `result` = 1001.
- **Over-shift and hold:**
  - count = 6, dir = 1, data = 1111 → 6 `sl` strobes, `result` = 0000.
  - The same command with `hold` high for 2 cycles mid-SHIFT → `done` 2 cycles later, `result` unchanged.
- **Abort:**
  - `abort` in the 2nd SHIFT cycle of a count-3 command → no strobe that cycle, IDLE next cycle, no `done`, `result` keeps its prior value.
  - A new command is then accepted immediately.
- **Busy rejection and back-to-back:**
  - `cmd_valid` held high during a command → exactly one accept per completion.
  - Check: strobes never overlap; `busy` = 0 exactly when `cmd_ready` = 1.
- **Reset:**
  - `rst` asserted in SHIFT → all outputs at reset values the next cycle.
  - After `rst` falls, a fresh command completes normally.

Source files
------------

// File: rtl/shift_ctrl.sv
// shift_ctrl: command sequencer for a WIDTH-bit load/shift-right/shift-left
// register. It accepts one command (load value, direction, shift count) over a
// valid/ready handshake. It drives the register strobes cycle by cycle and
// returns the settled register contents with a one-cycle done pulse.
module shift_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             hold,
  input  logic             abort,
  output logic             ld,
  output logic             sr,
  output logic             sl,
  output logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   data_r;
  logic               dir_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   remaining;
  logic               shift_en;
  logic               accept;

  // Handshake and status are pure decodes of the state. Ready is also masked
  // by rst, so nothing can be accepted on the edge that applies reset.
  assign cmd_ready = (state == S_IDLE) && !rst;
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign d_in      = data_r;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every sequential assignment is non-blocking, so all registers see
    // the values from before the edge no matter what order they are written in.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state and strobe decode. Abort forces strobes low in its own cycle.
  always_comb begin
    // NOTE: each output gets a default before the case statement. A path that
    // leaves one unassigned would infer a latch.
    next_state = state;
    ld         = 1'b0;
    sr         = 1'b0;
    sl         = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) next_state = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          next_state = S_IDLE;
        end else begin
          ld         = 1'b1;
          next_state = (count_r == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (!hold) begin
          shift_en = 1'b1;
          sr       = !dir_r;
          sl       = dir_r;
          if (remaining == CNT_W'(1)) next_state = S_DONE;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Command latch, shift countdown, result capture and the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= '0;
      dir_r     <= 1'b0;
      count_r   <= '0;
      remaining <= '0;
      result    <= '0;
      done      <= 1'b0;
    end else begin
      // The register has settled by the DONE cycle, so q_in is final here.
      done <= (state == S_DONE);
      if (state == S_DONE) result <= q_in;
      if (accept) begin
        data_r  <= cmd_data;
        dir_r   <= cmd_dir;
        count_r <= cmd_count;
      end
      if (ld)            remaining <= count_r;
      else if (shift_en) remaining <= remaining - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed bench for shift_ctrl with a behavioural shift
// register on the strobes. The stimulus pushes expected completions into a
// scoreboard, and a negedge monitor pops and compares them on every done pulse.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_data = '0;
  logic       cmd_dir = 1'b0;
  logic [2:0] cmd_count = '0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic       ld, sr, sl;
  logic [3:0] d_in;
  logic [3:0] q_in;
  logic       busy, done;
  logic [3:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [3:0] data;
    logic [3:0] res;
    int         n_sr;
    int         n_sl;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];

  shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .hold(hold), .abort(abort),
    .ld(ld), .sr(sr), .sl(sl), .d_in(d_in), .q_in(q_in),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controlled register: no reset of its own here, shifts fill with zero.
  logic [3:0] reg_q = 4'b0000;
  always @(posedge clk) begin
    if (ld)      reg_q <= d_in;
    else if (sr) reg_q <= reg_q >> 1;
    else if (sl) reg_q <= reg_q << 1;
  end
  assign q_in = reg_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: protocol invariants every cycle and scoreboard compare on done.
  initial begin
    int   n_ld, n_sr, n_sl;
    exp_t e;
    n_ld = 0; n_sr = 0; n_sl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_ld = 0; n_sr = 0; n_sl = 0;
      end else begin
        check("strobe_onehot0", 32'($countones({ld, sr, sl}) <= 1), 32'd1);
        check("busy_vs_ready", 32'(busy), 32'(!cmd_ready));
        if (done) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL done_unexpected: got done=1 expected no completion (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("result", 32'(result), 32'(e.res));
            check("done_cycle", 32'(cyc), 32'(e.done_cyc));
            check("ld_count", 32'(n_ld), 32'd1);
            check("sr_count", 32'(n_sr), 32'(e.n_sr));
            check("sl_count", 32'(n_sl), 32'(e.n_sl));
          end
        end
        if (ld && sb.size() > 0) check("d_in_at_ld", 32'(d_in), 32'(sb[0].data));
        n_ld += int'(ld);
        n_sr += int'(sr);
        n_sl += int'(sl);
        if (cmd_valid && cmd_ready) begin
          n_ld = 0; n_sr = 0; n_sl = 0;
        end
      end
    end
  end

  // Offer a command and wait (bounded) for acceptance. acc is the cycle number
  // of the accept edge's preceding cycle, so cycle k of the command is acc+k.
  task automatic issue(input logic [3:0] data, input logic dir, input logic [2:0] cnt,
                       input logic [3:0] exp_res, input int holds, input bit push,
                       output int acc);
    exp_t e;
    bit   got;
    got       = 1'b0;
    acc       = -1;
    cmd_data  = data;
    cmd_dir   = dir;
    cmd_count = cnt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no cmd_ready expected accept within 60 cycles");
    end else begin
      acc = cyc;
      if (push) begin
        e.data     = data;
        e.res      = exp_res;
        e.n_sr     = dir ? 0 : int'(cnt);
        e.n_sl     = dir ? int'(cnt) : 0;
        e.done_cyc = acc + int'(cnt) + 3 + holds;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got %0d pending expected 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int a, b;
    // Reset values while rst is high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_strobes", 32'({ld, sr, sl}), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_d_in", 32'(d_in), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Load + shift right: 1011 >> 2 = 0010.
    issue(4'b1011, 1'b0, 3'd2, 4'b0010, 0, 1'b1, a);
    wait_idle();

    // Shift left by 1 then count 0, valid kept high back to back.
    issue(4'b0011, 1'b1, 3'd1, 4'b0110, 0, 1'b1, a);
    issue(4'b1001, 1'b0, 3'd0, 4'b1001, 0, 1'b1, b);
    check("b2b_spacing", 32'(b - a), 32'd4);
    wait_idle();

    // Over-shift: 1111 << 6 = 0000.
    issue(4'b1111, 1'b1, 3'd6, 4'b0000, 0, 1'b1, a);
    wait_idle();

    // Same command with hold high in cycles 3 and 4 (mid-SHIFT).
    issue(4'b1111, 1'b1, 3'd6, 4'b0000, 2, 1'b1, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hold = 1'b1;
    #1;
    check("hold_no_strobe", 32'({sr, sl}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    hold = 1'b0;
    wait_idle();

    // Nonzero result to observe across the abort: 0110 >> 1 = 0011.
    issue(4'b0110, 1'b0, 3'd1, 4'b0011, 0, 1'b1, a);
    wait_idle();

    // Abort in the 2nd SHIFT cycle (cycle 3) of a count-3 command.
    issue(4'b1000, 1'b1, 3'd3, 4'b0000, 0, 1'b0, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    #1;
    check("abort_no_strobe", 32'({ld, sr, sl}), 32'd0);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_result_kept", 32'(result), 32'h3);
    issue(4'b0101, 1'b1, 3'd2, 4'b0100, 0, 1'b1, b);
    check("abort_reaccept", 32'(b - a), 32'd4);
    wait_idle();

    // Reset in SHIFT, then a fresh command.
    issue(4'b1100, 1'b0, 3'd5, 4'b0000, 0, 1'b1, a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("midrst_strobes", 32'({ld, sr, sl}), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_d_in", 32'(d_in), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", 32'(cmd_ready), 32'd1);
    issue(4'b1010, 1'b0, 3'd1, 4'b0101, 0, 1'b1, a);
    wait_idle();

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
